// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : timer_counter
// Description : Memory-mapped 32-bit down-counting timer with one-shot and
//               auto-reload modes, maskable interrupt and combinational reads.
//               Register map (addr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=rsvd.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  // Register selector values for addr[3:2]
  localparam logic [1:0] c_SEL_CTRL   = 2'd0;
  localparam logic [1:0] c_SEL_PRESET = 2'd1;
  localparam logic [1:0] c_SEL_COUNT  = 2'd2;

  // FSM encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_CNT  = 2'd2;
  localparam logic [1:0] c_ST_INT  = 2'd3;

  // Architectural state
  logic [3:0]  r_ctrl;      // [0]=EN, [2:1]=MODE, [3]=IM
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_if;
  logic        r_irq;
  logic [1:0]  r_state;

  // Next-state / decode wires
  logic [1:0]  w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_auto;
  logic        w_en_clr;
  logic        w_en_eff;
  logic [3:0]  w_ctrl_nxt;
  logic        w_if_nxt;
  logic        w_if_set;
  logic [31:0] w_count_nxt;
  logic [1:0]  w_state_nxt;
  logic        w_unused;

  assign w_sel       = addr[3:2];
  assign w_wr_ctrl   = we && (w_sel == c_SEL_CTRL);
  assign w_wr_preset = we && (w_sel == c_SEL_PRESET);

  // Only MODE=01 reloads; 10 and 11 fall back to one-shot behaviour.
  assign w_auto = (r_ctrl[2:1] == 2'b01);

  // One-shot expiry drops EN on the INT edge.
  assign w_en_clr = (r_state == c_ST_INT) && !w_auto;

  // EN as it will be after this edge. A bus write always wins over the
  // FSM clearing EN, and the FSM reacts to a new EN value at the write
  // edge itself, so an enable write enters LOAD immediately.
  assign w_en_eff = w_wr_ctrl ? din[0] : (r_ctrl[0] && !w_en_clr);

  assign w_ctrl_nxt = w_wr_ctrl ? din[3:0] : {r_ctrl[3:1], w_en_eff};

  // A CTRL write clears IF; otherwise INT sets it. Auto-reload lets it live
  // for one cycle only, one-shot holds it until software clears it.
  assign w_if_nxt = w_wr_ctrl ? 1'b0 :
                    w_if_set  ? 1'b1 :
                    w_auto    ? 1'b0 : r_if;

  // Address bits outside [3:2] are intentionally not decoded.
  assign w_unused = &{1'b0, addr[31:4], addr[1:0]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_en_eff) begin
          w_state_nxt = c_ST_LOAD;
        end
      end
      c_ST_LOAD: begin
        w_state_nxt = c_ST_CNT;
      end
      c_ST_CNT: begin
        if (!w_en_eff) begin
          w_state_nxt = c_ST_IDLE;
        end else if (r_count <= 32'd1) begin
          w_state_nxt = c_ST_INT;
        end
      end
      c_ST_INT: begin
        w_state_nxt = w_auto ? c_ST_LOAD : c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // FSM output logic: counter datapath and interrupt-flag set request
  always_comb begin
    w_count_nxt = r_count;
    w_if_set    = 1'b0;
    case (r_state)
      c_ST_LOAD: begin
        w_count_nxt = r_preset;
      end
      c_ST_CNT: begin
        // Saturate at zero; a PRESET of 0 or 1 both land on 0 here.
        if (w_en_eff) begin
          w_count_nxt = (r_count > 32'd1) ? (r_count - 32'd1) : 32'd0;
        end
      end
      c_ST_INT: begin
        w_if_set = 1'b1;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Register file, interrupt flag and registered irq output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_if     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_count <= w_count_nxt;
      r_if    <= w_if_nxt;
      r_irq   <= w_if_nxt && w_ctrl_nxt[3];
      if (w_wr_preset) begin
        r_preset <= din;
      end
    end
  end

  // Combinational read mux
  always_comb begin
    dout = 32'd0;
    case (w_sel)
      c_SEL_CTRL:   dout = {28'd0, r_ctrl};
      c_SEL_PRESET: dout = r_preset;
      c_SEL_COUNT:  dout = r_count;
      default:      dout = 32'd0;
    endcase
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_counter
// Description : Scoreboard bench for timer_counter; expected values are
//               queued when stimulus is applied and popped at sample time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  string       q_tag[$];
  logic [31:0] q_val[$];

  localparam logic [31:0] c_A_CTRL   = 32'h0000_7f00;
  localparam logic [31:0] c_A_PRESET = 32'h0000_7f04;
  localparam logic [31:0] c_A_COUNT  = 32'h0000_7f08;
  localparam logic [31:0] c_A_RSVD   = 32'h0000_7f0c;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    q_tag.push_back(tag);
    q_val.push_back(val);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (q_val.size() == 0) begin
      n_bad++;
      $display("FAIL sb_underflow: got 0x%08h, expected nothing queued", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_val.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic exp_rd(input string tag, input logic [31:0] a, input logic [31:0] val);
    logic [31:0] v;
    sb_push(tag, val);
    rd(a, v);
    sb_pop(v);
  endtask

  task automatic exp_irq(input string tag, input logic val);
    sb_push(tag, {31'd0, val});
    sb_pop({31'd0, irq});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    // Reset with a simultaneous CTRL write that must be ignored
    we = 1'b1; addr = c_A_CTRL; din = 32'hF;
    repeat (3) tick();
    we = 1'b0; reset = 1'b0;
    exp_rd("rst_ctrl",   c_A_CTRL,   32'd0);
    exp_rd("rst_preset", c_A_PRESET, 32'd0);
    exp_rd("rst_count",  c_A_COUNT,  32'd0);
    exp_rd("rst_rsvd",   c_A_RSVD,   32'd0);
    exp_irq("rst_irq", 1'b0);

    // One-shot: PRESET=5, CTRL=0x9
    wr(c_A_PRESET, 32'd5);
    wr(c_A_CTRL, 32'h9);
    for (int j = 1; j <= 7; j++) begin
      if (j <= 6) sb_push("os_count", 32'(6 - j));
      sb_push("os_irq", {31'd0, (j == 7)});
    end
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j <= 6) begin
        rd(c_A_COUNT, v);
        sb_pop(v);
      end
      sb_pop({31'd0, irq});
    end
    repeat (3) tick();
    exp_irq("os_irq_held", 1'b1);
    exp_rd("os_ctrl", c_A_CTRL, 32'h8);
    wr(c_A_CTRL, 32'h8);
    exp_irq("os_irq_clr", 1'b0);

    // Auto-reload: PRESET=3, CTRL=0xB -> 1-cycle pulse every 5 cycles
    wr(c_A_PRESET, 32'd3);
    wr(c_A_CTRL, 32'hB);
    for (int j = 1; j <= 21; j++) begin
      sb_push("ar_irq", {31'd0, (j >= 5) && ((j % 5) == 0)});
    end
    for (int j = 1; j <= 21; j++) begin
      tick();
      sb_pop({31'd0, irq});
    end
    exp_rd("ar_ctrl", c_A_CTRL, 32'hB);
    wr(c_A_CTRL, 32'h0);
    repeat (4) tick();
    exp_irq("ar_off_irq", 1'b0);

    // Masked one-shot: PRESET=2, CTRL=0x1
    wr(c_A_PRESET, 32'd2);
    wr(c_A_CTRL, 32'h1);
    for (int j = 1; j <= 6; j++) sb_push("mk_irq", 32'd0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      sb_pop({31'd0, irq});
    end
    exp_rd("mk_count", c_A_COUNT, 32'd0);
    exp_rd("mk_ctrl",  c_A_CTRL,  32'h0);
    wr(c_A_CTRL, 32'h8);
    exp_irq("mk_unmask_irq", 1'b0);
    repeat (2) tick();
    exp_irq("mk_unmask_irq2", 1'b0);

    // Disable mid-count and re-enable: PRESET=100, CTRL=0x9
    wr(c_A_PRESET, 32'd100);
    wr(c_A_CTRL, 32'h9);                 // edge t
    tick();                              // after t+1
    exp_rd("dis_load", c_A_COUNT, 32'd100);
    repeat (8) tick();                   // after t+9
    wr(c_A_CTRL, 32'h8);                 // edge t+10
    exp_rd("dis_frozen", c_A_COUNT, 32'd92);
    repeat (3) tick();
    exp_rd("dis_frozen2", c_A_COUNT, 32'd92);
    exp_irq("dis_irq", 1'b0);

    // Writes to COUNT and reserved addresses have no effect
    wr(c_A_COUNT, 32'h1234);
    exp_rd("ro_count", c_A_COUNT, 32'd92);
    wr(c_A_RSVD, 32'h5555);
    exp_rd("rsvd_ctrl",   c_A_CTRL,   32'h8);
    exp_rd("rsvd_preset", c_A_PRESET, 32'd100);
    exp_rd("rsvd_read",   c_A_RSVD,   32'd0);

    // Re-enable reloads instead of resuming
    wr(c_A_CTRL, 32'h9);
    exp_rd("re_load_state", c_A_COUNT, 32'd92);
    tick();
    exp_rd("re_reload", c_A_COUNT, 32'd100);
    tick();
    exp_rd("re_dec", c_A_COUNT, 32'd99);
    wr(c_A_CTRL, 32'h8);
    repeat (2) tick();

    // PRESET write during CNT applies only at the next LOAD
    wr(c_A_PRESET, 32'd10);
    wr(c_A_CTRL, 32'h9);                 // edge t
    repeat (2) tick();                   // after t+2
    exp_rd("pw_count", c_A_COUNT, 32'd9);
    wr(c_A_PRESET, 32'd50);              // edge t+3
    exp_rd("pw_count2", c_A_COUNT, 32'd8);
    exp_rd("pw_preset", c_A_PRESET, 32'd50);
    wr(c_A_CTRL, 32'h8);
    exp_rd("pw_frozen", c_A_COUNT, 32'd8);
    wr(c_A_CTRL, 32'h9);
    tick();
    exp_rd("pw_reload", c_A_COUNT, 32'd50);
    wr(c_A_CTRL, 32'h8);
    repeat (2) tick();

    // PRESET=0 behaves like 1: irq 3 cycles after enable
    wr(c_A_PRESET, 32'd0);
    wr(c_A_CTRL, 32'h9);
    for (int j = 1; j <= 3; j++) sb_push("p0_irq", {31'd0, (j == 3)});
    for (int j = 1; j <= 3; j++) begin
      tick();
      sb_pop({31'd0, irq});
    end
    exp_rd("p0_count", c_A_COUNT, 32'd0);
    wr(c_A_CTRL, 32'h8);
    exp_irq("p0_irq_clr", 1'b0);

    // Reset mid-operation
    wr(c_A_PRESET, 32'hFFFF_FFFF);
    wr(c_A_CTRL, 32'hB);                 // edge t
    repeat (20) tick();                  // after t+20
    exp_rd("mr_count", c_A_COUNT, 32'hFFFF_FFEC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd("mr_ctrl",   c_A_CTRL,   32'd0);
    exp_rd("mr_preset", c_A_PRESET, 32'd0);
    exp_rd("mr_count0", c_A_COUNT,  32'd0);
    exp_rd("mr_rsvd",   c_A_RSVD,   32'd0);
    exp_irq("mr_irq", 1'b0);
    repeat (5) tick();
    exp_rd("mr_count_idle", c_A_COUNT, 32'd0);
    exp_irq("mr_irq_idle", 1'b0);

    if (q_val.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d entries never compared", q_val.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 addr  input  32  byte address from the bridge; only addr[3:2] is decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved).
REQ-005 we  input  1  write strobe from the bridge, already qualified by the CPU's address range and interrupt state.
REQ-006 din  input  32  write data (the CPU's store data).
REQ-007 dout  output  32  read data returned to the bridge for loads.
REQ-008 irq  output  1  interrupt request, wired to one hwint bit of the CPU.

Function
REQ-009 CTRL SHALL be defined as follows:
- [0] EN: counter enable.
- [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
- [3] IM: interrupt mask, where 1 = irq allowed.
- [31:4] read as 0.
REQ-010 PRESET SHALL be a 32-bit read/write reload value; COUNT SHALL be a 32-bit read-only down-counter.
REQ-011 Reads SHALL be combinational: dout = CTRL / PRESET / COUNT for addr[3:2] = 0/1/2, and 0 for 3.
REQ-012 Writes SHALL take effect at the clock edge where we=1:
- addr[3:2]=0: CTRL <= din[3:0].
- addr[3:2]=1: PRESET <= din.
- addr[3:2]=2 or 3: ignored, no side effects.
REQ-013 Any CTRL write SHALL clear the internal interrupt flag (IF) at that same edge.
REQ-014 The FSM SHALL have states IDLE, LOAD, CNT, INT and SHALL transition as follows:
- IDLE: EN=1 -> LOAD; otherwise stay in IDLE.
- LOAD: COUNT <= PRESET -> CNT.
- CNT: EN=0 -> IDLE with COUNT held; COUNT>1 -> decrement and stay in CNT; COUNT<=1 -> COUNT <= 0 -> INT.
- INT: sets IF. In one-shot mode, clears EN -> IDLE. In auto-reload mode -> LOAD.
REQ-015 In one-shot mode, IF SHALL remain set until a CTRL write or reset clears it.
REQ-016 In auto-reload mode, IF SHALL be set for exactly one cycle (the cycle after INT) and then clear automatically.
REQ-017 irq SHALL equal IF & CTRL[3], registered with no combinational path from din or we.
REQ-018 Latency: with PRESET=N (N>=1) and EN written at edge t:
- LOAD at t+1.
- COUNT=N visible after t+1.
- COUNT reaches 0 after edge t+1+N.
- irq rises after edge t+2+N.
REQ-019 PRESET=0 SHALL behave like PRESET=1: CNT goes straight to INT, so irq rises 3 cycles after the EN write.
REQ-020 If a CTRL write and an FSM-driven EN clear occur at the same edge, the CTRL write SHALL win.
REQ-021 A PRESET write during CNT SHALL NOT alter COUNT; the new value applies at the next LOAD.
REQ-022 A CTRL write setting EN=0 during CNT SHALL freeze COUNT, and the FSM SHALL be in IDLE after the following edge.
REQ-023 Re-enabling from IDLE SHALL always pass through LOAD; a frozen count SHALL NOT resume.
REQ-024 The 32-bit decrement SHALL NOT wrap; COUNT SHALL never go below 0.

Reset
REQ-025 While reset=1 at an edge, the following SHALL be cleared: CTRL=0, PRESET=0, COUNT=0, IF=0, state=IDLE.
REQ-026 reset SHALL override any simultaneous write.
REQ-027 Reset mid-count SHALL abort the count with no irq.
REQ-028 After reset, dout SHALL be 0 for all addresses and irq SHALL be 0.

Verification
REQ-029 One-shot: PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; irq=1 exactly 7 cycles after the CTRL write and held; CTRL reads 0x8; writing CTRL=0x8 -> irq=0 next cycle.
REQ-030 Auto-reload: PRESET=3, CTRL=0xB -> irq pulses 1 cycle wide with a 5-cycle period (LOAD, 3 counts to 0, INT), repeating for 4 or more periods; EN stays 1.
REQ-031 Masked: PRESET=2, CTRL=0x1 -> COUNT reaches 0, irq stays 0, CTRL reads 0x0; then CTRL=0x8 -> irq stays 0 (IF cleared by the write).
REQ-032 Disable mid-count: PRESET=100, CTRL=0x9; after 10 cycles write CTRL=0x8 -> COUNT frozen at its value; re-enable -> COUNT reloads 100.
REQ-033 Boundaries:
- PRESET=0 with CTRL=0x9 -> irq 3 cycles after the write.
- A write to addr 0x7f08 with din=0x1234 -> COUNT unchanged.
- A read from addr 0x7f0c -> 0.
REQ-034 Reset mid-operation: PRESET=0xFFFFFFFF, CTRL=0xB, then reset=1 for 1 cycle after 20 cycles -> all registers read 0, irq=0, and no further counting.
